register_file: RTL and testbench
================================

Name: register_file

Overview:
- General-purpose register file for the pipelined CPU: 32 registers of 32 bits.
- Two combinational read ports serve the decode stage; one synchronous write port serves write-back.
- Register 0 is hardwired to zero (MIPS convention).
- Same-cycle write-to-read bypass lets decode observe the value being written back in that cycle.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports
- ADDR_WIDTH, 5, register address width; register count = 2**ADDR_WIDTH (32)

Ports:
- CLK  input  1  system clock; all register updates on rising edge
- RST_N  input  1  asynchronous active-low reset; clears all registers
- read1  input  ADDR_WIDTH  address for read port 1
- read2  input  ADDR_WIDTH  address for read port 2
- writeData  input  DATA_WIDTH  data to write
- RegWrite  input  1  write enable, active high
- write  input  ADDR_WIDTH  destination register address
- register1  output  DATA_WIDTH  contents addressed by read1
- register2  output  DATA_WIDTH  contents addressed by read2

Behaviour:
- Storage: array of 2**ADDR_WIDTH registers, each DATA_WIDTH bits.
- Reset:
  - RST_N low asynchronously clears every register to 0, regardless of CLK.
  - While RST_N is low, writes are blocked and register1/register2 read 0 for every address; the bypass path is also suppressed.
  - Release of reset takes effect cleanly: the first rising edge with RST_N high may write.
- Write:
  - On rising CLK with RST_N high and RegWrite=1 and write!=0, mem[write] <= writeData.
  - RegWrite=0: no register changes.
  - write==0: ignored; register 0 stays 0 permanently.
- Read: combinational, zero-cycle latency.
  - registerN = 0 if readN==0.
  - Otherwise registerN = writeData if (RegWrite && write==readN && RST_N), else mem[readN].
  - The bypass gives write-before-read semantics within a cycle; after the edge, the stored value matches the bypassed value.
- Both read ports are independent: same or different addresses, each may bypass at the same time.
- No X propagation from storage: all registers are defined after reset.
- Unknown/X on read address must not corrupt storage; the output may be X.
- Widths: no truncation or extension inside the block; addresses index the full array.

Test Plan:
1. Reset then read: assert RST_N=0 for 1 cycle, release, set read1=5, read2=31 -> register1=0, register2=0.
2. Sequential writes: RegWrite=1, write=1/2/3 with writeData=1/2/3 on successive rising edges; then read1=1, read2=2 -> register1=1, register2=2; then read1=0, read2=3 -> register1=0, register2=3.
3. Write disabled and reg 0: RegWrite=0, write=4, writeData=4 for one edge -> read 4 gives 0. RegWrite=1, write=0, writeData=0xFFFFFFFF -> read 0 gives 0, both before and after the edge.
4. Bypass: with reg 7 = 0x11, drive RegWrite=1, write=7, writeData=0xDEADBEEF, read1=read2=7 before the edge -> both ports show 0xDEADBEEF immediately. After the edge, with RegWrite=0 -> still 0xDEADBEEF.
5. Async reset mid-operation: after filling regs 1..3, pull RST_N low between clock edges -> outputs go 0 without waiting for CLK. After release, reading regs 1..3 -> 0.
6. Full sweep: write value (i*0x01010101) to every address 1..31, read back through both ports in parallel -> each matches; address 0 reads 0.

Source files
------------

// File: rtl/register_file.sv
// register_file: 32 x 32-bit general-purpose register file for the pipelined CPU.
// Two combinational read ports (decode) and one synchronous write port (write-back).
// Register 0 always reads zero. A write in flight is bypassed to any read port
// addressing the same register, so decode sees write-back data in the same cycle.

module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [ADDR_WIDTH-1:0] read1,
  input  logic [ADDR_WIDTH-1:0] read2,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] write,
  output logic [DATA_WIDTH-1:0] register1,
  output logic [DATA_WIDTH-1:0] register2
);

  localparam int                    NUM_REGS  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];
  logic                  wr_en;

  // A write is real only when enabled and not aimed at the hardwired zero register.
  assign wr_en = RegWrite && (write != ZERO_ADDR);

  // Next-state of the storage array: hold everything, overlay the write-back value.
  always_comb begin
    // NOTE: default the whole array first; any path that skips an assignment would infer a latch.
    for (int i = 0; i < NUM_REGS; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_en) begin
      mem_d[write] = writeData;
    end
  end

  // Storage update; reset clears every register so nothing ever reads back as X.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: this array is explicitly reset, so it maps to flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= ZERO_DATA;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read port 1: zero register, then reset mask, then bypass, then stored value.
  always_comb begin
    register1 = ZERO_DATA;
    if (read1 == ZERO_ADDR || !RST_N) begin
      register1 = ZERO_DATA;
    end else if (wr_en && (write == read1)) begin
      register1 = writeData;
    end else begin
      register1 = mem_q[read1];
    end
  end

  // Read port 2: same priority as port 1, fully independent of it.
  always_comb begin
    register2 = ZERO_DATA;
    if (read2 == ZERO_ADDR || !RST_N) begin
      register2 = ZERO_DATA;
    end else if (wr_en && (write == read2)) begin
      register2 = writeData;
    end else begin
      register2 = mem_q[read2];
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table-driven vectors plus hand-written reset/sweep sequences.
// Expected read values are queued when stimulus is driven and compared once the
// combinational outputs have settled, half a clock away from the active edge.

module tb_register_file;

  logic        CLK;
  logic        RST_N;
  logic [4:0]  read1;
  logic [4:0]  read2;
  logic [31:0] writeData;
  logic        RegWrite;
  logic [4:0]  write;
  logic [31:0] register1;
  logic [31:0] register2;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .read1     (read1),
    .read2     (read2),
    .writeData (writeData),
    .RegWrite  (RegWrite),
    .write     (write),
    .register1 (register1),
    .register2 (register2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    string       name;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] e1, input logic [31:0] e2, input string name);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.we = we; v.wa = wa; v.wd = wd;
    v.e1 = e1; v.e2 = e2; v.name = name;
    vecs.push_back(v);
  endtask

  // Drive one set of inputs, queue what both ports must show, then sample and compare.
  task automatic apply(input logic [4:0] r1, input logic [4:0] r2, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd,
                       input logic [31:0] e1, input logic [31:0] e2, input string name);
    exp_t x;
    read1 = r1; read2 = r2; RegWrite = we; write = wa; writeData = wd;
    x.e1 = e1; x.e2 = e2; x.name = name;
    sb.push_back(x);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, got none expected 1 entry", name);
    end else begin
      x = sb.pop_front();
      check({x.name, ".register1"}, register1, x.e1);
      check({x.name, ".register2"}, register2, x.e2);
    end
  endtask

  initial begin
    RST_N = 1'b0; read1 = '0; read2 = '0; RegWrite = 1'b0; write = '0; writeData = '0;

    // Each vector is one cycle: outputs checked before the edge, write commits on it.
    add_vec(5'd5,  5'd31, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        "reset_read");
    add_vec(5'd1,  5'd0,  1'b1, 5'd1, 32'h1,        32'h1,        32'h0,        "wr1_bypass");
    add_vec(5'd1,  5'd2,  1'b1, 5'd2, 32'h2,        32'h1,        32'h2,        "wr2_bypass");
    add_vec(5'd0,  5'd1,  1'b1, 5'd3, 32'h3,        32'h0,        32'h1,        "wr3");
    add_vec(5'd1,  5'd2,  1'b0, 5'd0, 32'h0,        32'h1,        32'h2,        "rd_1_2");
    add_vec(5'd0,  5'd3,  1'b0, 5'd0, 32'h0,        32'h0,        32'h3,        "rd_0_3");
    add_vec(5'd4,  5'd4,  1'b0, 5'd4, 32'h4,        32'h0,        32'h0,        "we_off_before");
    add_vec(5'd4,  5'd0,  1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        "we_off_after");
    add_vec(5'd0,  5'd0,  1'b1, 5'd0, 32'hFFFFFFFF, 32'h0,        32'h0,        "reg0_before");
    add_vec(5'd0,  5'd3,  1'b0, 5'd0, 32'h0,        32'h0,        32'h3,        "reg0_after");
    add_vec(5'd6,  5'd5,  1'b1, 5'd7, 32'h11,       32'h0,        32'h0,        "wr7_11");
    add_vec(5'd7,  5'd7,  1'b1, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, "bypass_both");
    add_vec(5'd7,  5'd7,  1'b0, 5'd7, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, "bypass_stored");
    add_vec(5'd5,  5'd6,  1'b1, 5'd5, 32'h0000AAAA, 32'h0000AAAA, 32'h0,        "bypass_one_port");
    add_vec(5'd7,  5'd5,  1'b0, 5'd5, 32'h12345678, 32'hDEADBEEF, 32'h0000AAAA, "we_off_wd_ignored");

    // Reset state, including a write attempt that must neither bypass nor land.
    @(negedge CLK);
    apply(5'd5, 5'd31, 1'b1, 5'd5, 32'h123, 32'h0, 32'h0, "in_reset_bypass");
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].r1, vecs[i].r2, vecs[i].we, vecs[i].wa, vecs[i].wd,
            vecs[i].e1, vecs[i].e2, vecs[i].name);
      @(negedge CLK);
    end

    // Async reset between edges: outputs drop without any clock edge.
    apply(5'd1, 5'd3, 1'b0, 5'd0, 32'h0, 32'h1, 32'h3, "pre_async");
    #2;
    RST_N = 1'b0;
    apply(5'd1, 5'd3, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, "async_no_edge");
    apply(5'd1, 5'd2, 1'b1, 5'd1, 32'h55, 32'h0, 32'h0, "async_wr_blocked");
    @(negedge CLK);
    apply(5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, "async_held");
    // First edge after release may already write.
    RST_N = 1'b1;
    apply(5'd9, 5'd3, 1'b1, 5'd9, 32'h99, 32'h99, 32'h0, "release_write");
    @(negedge CLK);
    apply(5'd9, 5'd7, 1'b0, 5'd0, 32'h0, 32'h99, 32'h0, "release_stored");
    apply(5'd1, 5'd3, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, "cleared_1_3");
    @(negedge CLK);

    // Full sweep: every register written with a distinct pattern, read through both ports.
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 1; i < 32; i++) begin
      model[i] = i * 32'h01010101;
      apply(5'(i), 5'd0, 1'b1, 5'(i), model[i], model[i], 32'h0, $sformatf("sweep_wr%0d", i));
      @(negedge CLK);
    end
    for (int i = 0; i < 32; i++) begin
      apply(5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, model[i], model[31 - i],
            $sformatf("sweep_rd%0d", i));
    end

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
